logic_issue_stage: RTL and testbench
====================================

# logic_issue_stage

Buffered issue/retire stage wrapped around the combinational logic unit. Accepts (a, b, op) commands over a valid/ready handshake, queues them in a DEPTH-entry FIFO, presents the head entry to the logic unit, and captures the returned result, with zero and illegal-op flags, into an output register that is drained over a second valid/ready handshake. Sustains one operation per cycle when downstream is ready.

## Interface
- DATA_WIDTH, 8: operand/result width; must match the logic unit.
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- CW: derived, $clog2(DEPTH)+1; width of count.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a, in_b  in  DATA_WIDTH  operands.
- in_op  in  3  logic opcode; 000 AND, 001 OR, 010 XOR, 011 NOT a, 100 NAND, 101 NOR, 110 XNOR, 111 illegal.
- lu_a, lu_b  out  DATA_WIDTH  to logic unit; head entry operands, 0 when FIFO empty.
- lu_op  out  3  to logic unit; head entry opcode, 000 when FIFO empty.
- lu_result  in  DATA_WIDTH  from logic unit; combinational function of lu_a, lu_b, lu_op.
- out_valid  out  1  result register holds unconsumed data.
- out_ready  in  1  downstream accepts.
- out_result  out  DATA_WIDTH  registered result.
- out_zero  out  1  out_result == 0.
- out_illegal  out  1  captured op was 111; out_result is 0 in that case.
- count  out  CW  FIFO occupancy, 0..DEPTH.

## Operation
- push = in_valid && in_ready. Writes {in_a, in_b, in_op} at wr_ptr. wr_ptr advances mod DEPTH.
- load = !empty && (!out_valid || out_ready). Captures lu_result, zero flag and illegal flag into the output register. Pops the head, and rd_ptr advances mod DEPTH.
- Output register: out_valid is set on load. It is cleared when out_ready && out_valid && !load. When load coincides with a drain, out_valid stays 1 and new data replaces the old.
- Backpressure: while out_valid && !out_ready, out_* and the FIFO head hold stable, and the FIFO fills. in_ready drops when count == DEPTH.
- Simultaneous push and pop: count is unchanged, and both pointers advance. This is legal at count 0? No: when count is 0, load is 0, so only the push takes effect.
- Full: in_ready = 0. Push is blocked even if a pop happens in the same cycle, because in_ready does not look ahead.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are derived from count.
- Illegal op 111: passes through the FIFO normally, and out_illegal = 1. out_result takes whatever lu_result returns (0 by logic unit default).
- in_a/in_b/in_op are ignored when push = 0. out_ready is ignored when out_valid = 0.

## Timing
- Reset (rst_n low, asynchronous): count = 0, pointers = 0, out_valid = 0, out_result = 0, out_zero = 0, out_illegal = 0. Consequently in_ready = 1, lu_a = 0, lu_b = 0, lu_op = 000.
- Reset mid-operation: all queued commands and any pending result are discarded, with no partial output. FIFO storage needs no reset.
- Latency: a command pushed at edge N is in the FIFO after N. With out_ready = 1 it is loaded at edge N+1, so out_valid is high from N+1 until it is consumed. Minimum latency is 1 cycle after acceptance; there is no combinational in-to-out path.
- Throughput: 1 command/cycle with in_valid = 1 and out_ready = 1 continuously; count stays at 1 in steady state.
- in_ready, count, lu_*, out_* are functions of registers only. lu_result is sampled only at a load edge.
- Ordering: results leave strictly in acceptance order.

## Test plan
- Reset/idle: assert rst_n = 0 mid-stream with 3 entries queued and out_valid = 1. Required: immediately count = 0, out_valid = 0, out_result = 0, in_ready = 1. No output after release.
- Single op: push a = 8'hF0, b = 8'h3C, op = 000 with out_ready = 1. Required: out_valid one cycle later, out_result = 8'h30, out_zero = 0, out_illegal = 0.
- Streaming: push all 8 opcodes back-to-back, a = 8'hAA, b = 8'h55, with out_ready = 1. Required, in order: 00, FF, FF, 55, FF, 00, 00, 00. out_zero is 1 on entries 1, 6, 7 and 8. out_illegal is 1 only on the 8th. There is no bubble after the first result.
- Backpressure/full: hold out_ready = 0 and push 6 commands. Required: first result held stable. count reaches 4 (DEPTH) after 5 accepted (1 in output register). in_ready = 0 from then on, and the 6th is stalled.
- Drain with wrap: from that full state, release out_ready = 1 while continuing to push 10 more commands. Required: all 15 results in order, pointers wrap twice, count never exceeds 4, and no loss or duplication.
- Push/pop same cycle at count 2 with out_valid = 1 and out_ready = 1. Required: count stays 2 and out_result updates to the next head.

Source files
------------

// File: rtl/logic_issue_stage.sv
// Buffered issue/retire stage: a command FIFO feeds an external combinational
// logic unit, and each result is captured into a drainable output register.
module logic_issue_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Both handshakes: a transfer happens on a rising edge where valid && ready.
  // Once valid is raised, the payload holds stable until that transfer.
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_op,
  output logic [DATA_WIDTH-1:0] lu_a,
  output logic [DATA_WIDTH-1:0] lu_b,
  output logic [2:0]            lu_op,
  input  logic [DATA_WIDTH-1:0] lu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_illegal,
  output logic [CW-1:0]         count
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0]    OP_ILL  = 3'b111;

  // Storage is deliberately unreset: an entry is only read while count covers it.
  logic [DATA_WIDTH-1:0] a_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem  [DEPTH];
  logic [2:0]            op_mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
  logic                  out_zero_q, out_zero_d;
  logic                  out_illegal_q, out_illegal_d;

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  load;
  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic [2:0]            head_op;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // in_ready does not look ahead at a same-cycle pop, so a full FIFO blocks.
  assign push  = in_valid && !full;
  assign load  = !empty && (!out_valid_q || out_ready);

  assign head_a  = a_mem[rd_ptr_q];
  assign head_b  = b_mem[rd_ptr_q];
  assign head_op = op_mem[rd_ptr_q];

  assign lu_a  = empty ? '0 : head_a;
  assign lu_b  = empty ? '0 : head_b;
  assign lu_op = empty ? 3'b000 : head_op;

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q]  <= in_a;
      b_mem[wr_ptr_q]  <= in_b;
      op_mem[wr_ptr_q] <= in_op;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (load) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A load during a drain simply overwrites the consumed result.
    if (load) begin
      out_valid_d   = 1'b1;
      out_result_d  = lu_result;
      out_zero_d    = (lu_result == '0);
      out_illegal_d = (head_op == OP_ILL);
    end else if (out_valid_q && out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign in_ready    = !full;
  assign count       = count_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_logic_issue_stage.sv
// Directed bench for logic_issue_stage; a behavioural logic unit closes the
// lu_* loop so the stage sees realistic combinational results.
module tb_logic_issue_stage;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [2:0]    in_op;
  logic [DW-1:0] lu_a;
  logic [DW-1:0] lu_b;
  logic [2:0]    lu_op;
  logic [DW-1:0] lu_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_illegal;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  logic_issue_stage #(.DATA_WIDTH(DW), .DEPTH(4), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_result(lu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (lu_op)
      3'b000:  lu_result = lu_a & lu_b;
      3'b001:  lu_result = lu_a | lu_b;
      3'b010:  lu_result = lu_a ^ lu_b;
      3'b011:  lu_result = ~lu_a;
      3'b100:  lu_result = ~(lu_a & lu_b);
      3'b101:  lu_result = ~(lu_a | lu_b);
      3'b110:  lu_result = ~(lu_a ^ lu_b);
      default: lu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_res  [8];
    logic       exp_zero [8];
    logic [3:0] k;
    logic [3:0] k_exp;
    logic       accept;
    int         n_got;

    exp_res  = '{8'h00, 8'hFF, 8'hFF, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00};
    exp_zero = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_zero", 32'(out_zero), 0);
    chk("rst_out_illegal", 32'(out_illegal), 0);
    chk("rst_lu_a", 32'(lu_a), 0);
    chk("rst_lu_op", 32'(lu_op), 0);
    rst_n = 1'b1;
    tick();

    // Single op
    in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_op = 3'b000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_count", 32'(count), 1);
    chk("single_no_early_valid", 32'(out_valid), 0);
    chk("single_lu_a", 32'(lu_a), 32'hF0);
    tick();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_result", 32'(out_result), 32'h30);
    chk("single_zero", 32'(out_zero), 0);
    chk("single_illegal", 32'(out_illegal), 0);
    chk("single_count_after", 32'(count), 0);
    tick();
    chk("single_drained", 32'(out_valid), 0);

    // Streaming: all 8 opcodes back to back
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_op = 3'd0;
    tick();
    chk("stream_first_count", 32'(count), 1);
    chk("stream_first_no_valid", 32'(out_valid), 0);
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) in_op = 3'(i);
      else       in_valid = 1'b0;
      tick();
      chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("stream_result_%0d", i), 32'(out_result), 32'(exp_res[i-1]));
      chk($sformatf("stream_zero_%0d", i), 32'(out_zero), 32'(exp_zero[i-1]));
      chk($sformatf("stream_illegal_%0d", i), 32'(out_illegal), (i == 8) ? 1 : 0);
      chk($sformatf("stream_count_%0d", i), 32'(count), (i < 8) ? 1 : 0);
    end
    tick();
    chk("stream_done", 32'(out_valid), 0);

    // Backpressure: command k computes {k,4'h0} | {4'h0,k} = {k,k}
    out_ready = 1'b0;
    in_valid  = 1'b1; in_op = 3'b001;
    k = 4'd1;
    for (int i = 0; i < 5; i++) begin
      in_a = {k, 4'h0}; in_b = {4'h0, k};
      tick();
      k = k + 4'd1;
    end
    chk("bp_count_full", 32'(count), 4);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_first_held", 32'(out_result), 32'h11);
    chk("bp_head_a", 32'(lu_a), 32'h20);
    in_a = {k, 4'h0}; in_b = {4'h0, k};
    tick();
    tick();
    chk("bp_stall_count", 32'(count), 4);
    chk("bp_stall_in_ready", 32'(in_ready), 0);
    chk("bp_stall_result", 32'(out_result), 32'h11);

    // Drain with wrap, pushing k = 6..15 as room appears
    out_ready = 1'b1;
    k_exp = 4'd1;
    n_got = 0;
    for (int cyc = 0; cyc < 60 && n_got < 15; cyc++) begin
      in_valid = (k != 4'd0);
      in_a = {k, 4'h0}; in_b = {4'h0, k};
      accept = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("drain_result_%0d", k_exp), 32'(out_result), 32'({k_exp, k_exp}));
        k_exp = k_exp + 4'd1;
        n_got++;
      end
      tick();
      if (accept) k = k + 4'd1;
      chk("drain_count_le_depth", 32'(count <= 3'd4), 1);
    end
    in_valid = 1'b0;
    chk("drain_total", 32'(n_got), 15);
    tick();
    chk("drain_empty_count", 32'(count), 0);
    chk("drain_empty_valid", 32'(out_valid), 0);

    // Push and pop in the same cycle at count 2
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b000; in_a = 8'hFF;
    in_b = 8'h81; tick();
    in_b = 8'h42; tick();
    in_b = 8'h24; tick();
    chk("pp_setup_count", 32'(count), 2);
    chk("pp_setup_result", 32'(out_result), 32'h81);
    out_ready = 1'b1; in_b = 8'h18;
    tick();
    in_valid = 1'b0;
    chk("pp_count_same", 32'(count), 2);
    chk("pp_result_next", 32'(out_result), 32'h42);
    chk("pp_valid", 32'(out_valid), 1);
    tick();
    chk("pp_result_3", 32'(out_result), 32'h24);
    tick();
    chk("pp_result_4", 32'(out_result), 32'h18);
    chk("pp_count_empty", 32'(count), 0);
    tick();
    chk("pp_done", 32'(out_valid), 0);

    // Reset mid-stream with 3 queued and a pending result
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b001; in_a = 8'h0F; in_b = 8'hF0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_setup_count", 32'(count), 3);
    chk("mid_setup_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_result", 32'(out_result), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    #3;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_output", 32'(out_valid), 0);
    end
    chk("post_rst_count", 32'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
